grf_multiport: RTL and testbench

Parametrised general register file for the next-generation pipelined CPU: configurable data width, depth, read-port count and write-port count, with same-cycle write-to-read bypass and a per-register busy scoreboard for long-latency units (mult/div). Sits in the decode stage; read ports feed operand fetch and hazard logic, write ports are driven by the writeback stage and the long-latency unit's completion path.

---
 rtl/grf_pkg.sv | 10 +
 rtl/grf_multiport_if.sv | 31 +++
 rtl/grf_scoreboard.sv | 72 +++++++
 rtl/grf_multiport.sv | 95 +++++++++
 tb/tb_grf_multiport.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/grf_pkg.sv
// Shared defaults and types for the general register file.
// Imported by the interface, the scoreboard and the top.
package grf_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int unsigned ZERO_REG = 32'd0;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
endpackage

// File: rtl/grf_multiport_if.sv
// Register-file port bundle: read, write and reservation buses.
// The decode stage is the master; the register file is the slave.
interface grf_multiport_if
    import grf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
) ();
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/grf_scoreboard.sv
// Per-register busy bits for long-latency destinations plus a registered
// population count. Flush beats reserve, reserve beats write-clear.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [(2**ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic [ADDR_W:0]  cnt_r;
    logic             clr_s;
    logic             set_s;

    function automatic logic [ADDR_W:0] popcnt(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Next busy vector from flush, reservation and write-completion requests
    always_comb begin
        busy_nxt_s = {DEPTH{1'b0}};
        clr_s      = 1'b0;
        set_s      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_s = 1'b0;
            for (int w = 0; w < NUM_WR; w++) begin
                clr_s = clr_s | (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i)));
            end
            set_s = rsv_en && (rsv_addr == ADDR_W'(i));
            if (flush || (i == ZERO_REG)) begin
                busy_nxt_s[i] = 1'b0;
            end else if (set_s) begin
                busy_nxt_s[i] = 1'b1;
            end else if (clr_s) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Busy bits and their count update together on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= {DEPTH{1'b0}};
            cnt_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= popcnt(busy_nxt_s);
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = cnt_r;
endmodule

// File: rtl/grf_multiport.sv
// Multi-port general register file: storage array, write arbitration
// (highest port wins), same-cycle bypass and busy lookup per read port.
module grf_multiport
    import grf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          reset,
    grf_multiport_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_s;
    logic [ADDR_W:0]   busy_cnt_s;
    logic [ADDR_W-1:0] rd_a_s [NUM_RD];
    logic [ADDR_W-1:0] wr_a_s [NUM_WR];
    logic [DATA_W-1:0] wr_d_s [NUM_WR];
    logic [DATA_W-1:0] port_d_s [NUM_RD];
    logic              port_f_s [NUM_RD];
    logic              hit_s;
    logic [NUM_RD*DATA_W-1:0] rd_data_s;
    logic [NUM_RD-1:0]        rd_busy_s;

    grf_scoreboard #(.ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .flush    (bus.flush),
        .busy     (busy_s),
        .busy_cnt (busy_cnt_s)
    );

    // Unpack flat port buses into per-port fields
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_a_s[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
        end
        for (int w = 0; w < NUM_WR; w++) begin
            wr_a_s[w] = bus.wr_addr[w*ADDR_W +: ADDR_W];
            wr_d_s[w] = bus.wr_data[w*DATA_W +: DATA_W];
        end
    end

    // Storage; later ports are applied last so the highest port wins a conflict
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && (wr_a_s[w] != ADDR_W'(ZERO_REG))) begin
                    mem_r[wr_a_s[w]] <= wr_d_s[w];
                end
            end
        end
    end

    // Read muxes with bypass; a forwarded write hides busy unless re-reserved
    always_comb begin
        rd_data_s = {(NUM_RD*DATA_W){1'b0}};
        rd_busy_s = {NUM_RD{1'b0}};
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            port_d_s[k] = mem_r[rd_a_s[k]];
            port_f_s[k] = 1'b0;
            for (int w = 0; w < NUM_WR; w++) begin
                hit_s = (BYPASS != 32'sd0) && bus.wr_en[w] && (wr_a_s[w] == rd_a_s[k]);
                port_d_s[k] = hit_s ? wr_d_s[w] : port_d_s[k];
                port_f_s[k] = port_f_s[k] | hit_s;
            end
            if (!reset || (rd_a_s[k] == ADDR_W'(ZERO_REG))) begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy_s[k] = 1'b0;
            end else begin
                rd_data_s[k*DATA_W +: DATA_W] = port_d_s[k];
                rd_busy_s[k] = busy_s[rd_a_s[k]] &&
                               !(port_f_s[k] && !(bus.rsv_en && (bus.rsv_addr == rd_a_s[k])));
            end
        end
    end

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.busy_cnt = busy_cnt_s;
endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport: reset, bypass, index 0, scoreboard,
// flush and mid-run reset, with hand-computed expectations.
module tb_grf_multiport;
    import grf_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    grf_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 2'b00;
        bus.wr_addr  = 10'd0;
        bus.wr_data  = 64'd0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = 5'd0;
        bus.flush    = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        bus.rd_addr[k*AW +: AW] = a;
    endtask

    task automatic chk_port(input string tag, input int k, input logic [31:0] d, input logic b);
        check({tag, "_data"}, bus.rd_data[k*DW +: DW], d);
        check({tag, "_busy"}, {31'd0, bus.rd_busy[k]}, {31'd0, b});
    endtask

    initial begin
        reset = 1'b0;
        bus.rd_addr = 15'd0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("cnt_in_reset", {26'd0, bus.busy_cnt}, 32'd0);
        reset = 1'b1;
        tick();

        // all indices on all ports read zero after reset
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < NR; k++) set_rd(k, 5'(i));
            #1;
            for (int k = 0; k < NR; k++) chk_port("post_reset", k, 32'd0, 1'b0);
        end
        check("post_reset_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        // write-write conflict on $5, port 1 wins, bypassed same cycle
        bus.wr_en   = 2'b11;
        bus.wr_addr = {5'd5, 5'd5};
        bus.wr_data = {32'h0000ABCD, 32'h00001234};
        set_rd(0, 5'd5);
        set_rd(1, 5'd5);
        #1;
        chk_port("ww_bypass", 0, 32'h0000ABCD, 1'b0);
        tick();
        idle();
        #1;
        chk_port("ww_array_p0", 0, 32'h0000ABCD, 1'b0);
        chk_port("ww_array_p1", 1, 32'h0000ABCD, 1'b0);

        // index 0 ignores writes and reservations
        bus.wr_en    = 2'b01;
        bus.wr_addr  = {5'd0, 5'd0};
        bus.wr_data  = {32'd0, 32'hFFFFFFFF};
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd0;
        set_rd(0, 5'd0);
        #1;
        chk_port("r0_same", 0, 32'd0, 1'b0);
        tick();
        idle();
        #1;
        chk_port("r0_next", 0, 32'd0, 1'b0);
        check("r0_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        // reserve $8, then completion write clears it
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd8;
        tick();
        idle();
        set_rd(1, 5'd8);
        #1;
        chk_port("rsv8", 1, 32'd0, 1'b1);
        check("rsv8_cnt", {26'd0, bus.busy_cnt}, 32'd1);
        bus.wr_en   = 2'b10;
        bus.wr_addr = {5'd8, 5'd0};
        bus.wr_data = {32'd7, 32'd0};
        #1;
        chk_port("wr8_fwd", 1, 32'd7, 1'b0);
        check("wr8_cnt_same", {26'd0, bus.busy_cnt}, 32'd1);
        tick();
        idle();
        #1;
        chk_port("wr8_next", 1, 32'd7, 1'b0);
        check("wr8_cnt_next", {26'd0, bus.busy_cnt}, 32'd0);

        // reserve $3,$4,$3 again,$9 -> three busy
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd3; tick();
        bus.rsv_addr = 5'd4; tick();
        bus.rsv_addr = 5'd3; tick();
        check("rersv_cnt", {26'd0, bus.busy_cnt}, 32'd2);
        bus.rsv_addr = 5'd9; tick();
        idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        set_rd(2, 5'd9);
        #1;
        chk_port("multi3", 0, 32'd0, 1'b1);
        chk_port("multi4", 1, 32'd0, 1'b1);
        chk_port("multi9", 2, 32'd0, 1'b1);
        check("multi_cnt", {26'd0, bus.busy_cnt}, 32'd3);

        // flush overrides a same-cycle reservation of $10
        bus.flush    = 1'b1;
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd10;
        tick();
        idle();
        set_rd(2, 5'd10);
        #1;
        chk_port("flush3", 0, 32'd0, 1'b0);
        chk_port("flush4", 1, 32'd0, 1'b0);
        chk_port("flush10", 2, 32'd0, 1'b0);
        check("flush_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        // reserve and write $6 together: data lands, busy stays set
        bus.wr_en    = 2'b01;
        bus.wr_addr  = {5'd0, 5'd6};
        bus.wr_data  = {32'd0, 32'h00000055};
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd6;
        set_rd(2, 5'd6);
        #1;
        chk_port("rw6_same", 2, 32'h00000055, 1'b0);
        tick();
        idle();
        #1;
        chk_port("rw6_next", 2, 32'h00000055, 1'b1);
        check("rw6_cnt", {26'd0, bus.busy_cnt}, 32'd1);

        // reset asserted mid-cycle with a write in flight
        bus.wr_en   = 2'b01;
        bus.wr_addr = {5'd0, 5'd7};
        bus.wr_data = {32'd0, 32'h0000DEAD};
        set_rd(0, 5'd7);
        #1;
        chk_port("pre_rst_fwd", 0, 32'h0000DEAD, 1'b0);
        reset = 1'b0;
        #1;
        chk_port("rst_p0", 0, 32'd0, 1'b0);
        chk_port("rst_p2", 2, 32'd0, 1'b0);
        check("rst_cnt", {26'd0, bus.busy_cnt}, 32'd0);
        tick();
        idle();
        #1;
        reset = 1'b1;
        tick();
        set_rd(0, 5'd7);
        set_rd(1, 5'd5);
        #1;
        chk_port("after_rst7", 0, 32'd0, 1'b0);
        chk_port("after_rst5", 1, 32'd0, 1'b0);
        chk_port("after_rst6", 2, 32'd0, 1'b0);
        check("after_rst_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
